i2c_reg_target: RTL and testbench

I2C target (slave) that receives register write and read transactions from an I2C initiator. It responds at a parameterised 7-bit address and runs the standard pointer-then-data register protocol with auto-increment. It exposes a simple write-strobe and read-data port to fabric register logic. It lets the board-side register behaviour of the clock-chip configuration flow be modelled and checked in hardware or simulation, and gives the design its own I2C-configurable register space.

---
 rtl/i2c_reg_target.sv | 196 +++++++++++++++++++
 tb/tb_i2c_reg_target.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_target.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_target
//  Purpose  : I2C target with a pointer-then-data register protocol and
//             auto-increment. Fabric register logic sees a write strobe
//             port and a combinational or 1-cycle read-data port.
//  Ports    : clk, rst_n (sync, active-low)
//             scl (in), sda (inout, open-drain, pulled low only)
//             wr_stb / wr_addr / wr_data : one pulse per accepted write byte
//             rd_addr / rd_data          : pointer out, register contents in
//             busy                       : START seen, STOP not yet seen
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_reg_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h68
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_IGNORE = 3'd2;
  localparam logic [2:0] S_REG    = 3'd3;
  localparam logic [2:0] S_WDATA  = 3'd4;
  localparam logic [2:0] S_RDATA  = 3'd5;

  logic [1:0] r_scl_sync, r_sda_sync;
  logic       r_scl_d, r_sda_d;
  logic [2:0] r_state, w_next;
  logic [3:0] r_cnt;      // SCL rises seen in the current 9-clock frame
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_oe;
  logic       r_ack;      // ACK decision for the byte in flight
  logic       r_rw;
  logic       r_wr_stb;
  logic [7:0] r_wr_addr, r_wr_data;

  logic       w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic       w_match;

  // Synchronizers reset to the idle-bus level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl};
      r_sda_sync <= {r_sda_sync[0], sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  // Byte as it will look once the bit on the current SCL rise is shifted in.
  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_match    = (w_byte[7:1] == SLAVE_ADDR);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state. STOP beats everything, START beats the rest.
  always_comb begin
    w_next = r_state;
    if (w_stop) begin
      w_next = S_IDLE;
    end else if (w_start) begin
      w_next = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:
          if (w_scl_rise && r_cnt == 4'd8)
            w_next = r_ack ? (r_rw ? S_RDATA : S_REG) : S_IGNORE;
        S_REG:
          if (w_scl_rise && r_cnt == 4'd8) w_next = S_WDATA;
        S_RDATA:
          if (w_scl_rise && r_cnt == 4'd8 && w_sda) w_next = S_IGNORE;
        default: w_next = r_state;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state != S_IDLE);
  end

  // Datapath: bit counter, shift register, pointer, SDA drive, write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= 4'd0;
      r_shift   <= 8'd0;
      r_ptr     <= 8'd0;
      r_oe      <= 1'b0;
      r_ack     <= 1'b0;
      r_rw      <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= 8'd0;
      r_wr_data <= 8'd0;
    end else begin
      r_wr_stb <= 1'b0;
      // Pointer advances the cycle after each write strobe.
      if (r_wr_stb) r_ptr <= r_ptr + 8'd1;
      if (w_stop || w_start) begin
        // Any partial byte is simply dropped: nothing commits before bit 8.
        r_cnt <= 4'd0;
        r_oe  <= 1'b0;
        r_ack <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_REG, S_WDATA: begin
            if (w_scl_rise) begin
              if (r_cnt < 4'd8) begin
                r_shift <= w_byte;
                r_cnt   <= r_cnt + 4'd1;
                if (r_cnt == 4'd7) begin
                  if (r_state == S_ADDR) begin
                    r_ack <= w_match;
                    r_rw  <= w_byte[0];
                  end else if (r_state == S_REG) begin
                    r_ptr <= w_byte;
                    r_ack <= 1'b1;
                  end else begin
                    r_wr_stb  <= 1'b1;
                    r_wr_addr <= r_ptr;
                    r_wr_data <= w_byte;
                    r_ack     <= 1'b1;
                  end
                end
              end else begin
                r_cnt <= 4'd0;        // 9th (ACK) clock closes the frame
              end
            end else if (w_scl_fall) begin
              if (r_cnt == 4'd8)      r_oe <= r_ack;
              else if (r_cnt == 4'd0) r_oe <= 1'b0;
            end
          end
          S_RDATA: begin
            if (w_scl_rise) begin
              if (r_cnt < 4'd8) begin
                r_cnt <= r_cnt + 4'd1;
              end else begin
                // Initiator ACK/NACK sampled here; pointer moves either way.
                r_cnt <= 4'd0;
                r_ptr <= r_ptr + 8'd1;
              end
            end else if (w_scl_fall) begin
              if (r_cnt == 4'd0) begin
                r_shift <= rd_data;
                r_oe    <= ~rd_data[7];
              end else if (r_cnt < 4'd8) begin
                r_shift <= {r_shift[6:0], 1'b0};
                r_oe    <= ~r_shift[6];
              end else begin
                r_oe    <= 1'b0;      // let the initiator drive its ACK
              end
            end
          end
          default: begin
            r_cnt <= 4'd0;
            r_oe  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda     = r_oe ? 1'b0 : 1'bz;
  assign wr_stb  = r_wr_stb;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_ptr;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_reg_target
//  Purpose  : Self-checking bench for i2c_reg_target. An I2C initiator model
//             drives directed and $urandom transactions; a behavioural model
//             (pointer plus register array) predicts strobes and read bytes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_target;

  localparam int Q = 6;  // quarter SCL period in clk cycles (SCL = clk/24)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       sda_drv_low;
  wire        sda;
  logic       wr_stb;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       busy;

  always #5 clk = ~clk;

  assign sda = sda_drv_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_reg_target #(.SLAVE_ADDR(7'h68)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (scl),
    .sda     (sda),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy)
  );

  // Fabric-side register file: unwritten locations read as addr ^ 0xA5.
  logic [7:0] fab_mem   [256];
  logic       fab_valid [256];
  logic       fab_clear;
  logic [15:0] got_wr [$];

  assign rd_data = fab_valid[rd_addr] ? fab_mem[rd_addr] : (rd_addr ^ 8'hA5);

  always @(negedge clk) begin
    if (fab_clear) begin
      for (int i = 0; i < 256; i++) fab_valid[i] <= 1'b0;
    end else if (wr_stb) begin
      got_wr.push_back({wr_addr, wr_data});
      fab_mem[wr_addr]   <= wr_data;
      fab_valid[wr_addr] <= 1'b1;
    end
  end

  // Reference model
  logic [7:0]  model_mem [256];
  logic [7:0]  model_ptr;
  logic [15:0] exp_wr [$];
  logic [7:0]  wq [$];

  int checks = 0;
  int failures = 0;
  int stray_drive = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_drv_low = ~b;
    wait_q(1);
    scl = 1'b1;
    wait_q(1);
    if (b && sda == 1'b0) stray_drive++;
    wait_q(1);
    scl = 1'b0;
    wait_q(1);
  endtask

  task automatic recv_bit(output logic b);
    sda_drv_low = 1'b0;
    wait_q(1);
    scl = 1'b1;
    wait_q(1);
    b = sda;
    wait_q(1);
    scl = 1'b0;
    wait_q(1);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack_it);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack_it);
  endtask

  task automatic i2c_start;
    sda_drv_low = 1'b0;
    wait_q(1);
    scl = 1'b1;
    wait_q(1);
    sda_drv_low = 1'b1;
    wait_q(1);
    scl = 1'b0;
    wait_q(1);
  endtask

  task automatic i2c_stop;
    sda_drv_low = 1'b1;
    wait_q(1);
    scl = 1'b1;
    wait_q(1);
    sda_drv_low = 1'b0;
    wait_q(2);
  endtask

  // Compare strobes, pointer, busy and stray drives after a transaction.
  task automatic check_txn(input string tag);
    chk_eq({tag, "_wr_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      chk_eq({tag, "_wr"}, (i < got_wr.size()) ? 32'(got_wr[i]) : 32'hDEAD_BEEF,
             32'(exp_wr[i]));
    chk_eq({tag, "_rd_addr"}, 32'(rd_addr), 32'(model_ptr));
    chk_eq({tag, "_busy"}, 32'(busy), 32'd0);
    chk_eq({tag, "_stray_sda"}, 32'(stray_drive), 32'd0);
    got_wr.delete();
    exp_wr.delete();
    stray_drive = 0;
  endtask

  // Write transaction: pointer byte then the bytes queued in wq.
  task automatic write_txn(input string tag, input logic [7:0] reg_addr);
    logic ack;
    i2c_start();
    chk_eq({tag, "_busy_on"}, 32'(busy), 32'd1);
    send_byte(8'hD0, ack);
    chk_eq({tag, "_ack_addr"}, 32'(ack), 32'd1);
    send_byte(reg_addr, ack);
    chk_eq({tag, "_ack_reg"}, 32'(ack), 32'd1);
    model_ptr = reg_addr;
    foreach (wq[k]) begin
      send_byte(wq[k], ack);
      chk_eq({tag, "_ack_data"}, 32'(ack), 32'd1);
      exp_wr.push_back({model_ptr, wq[k]});
      model_mem[model_ptr] = wq[k];
      model_ptr = model_ptr + 8'd1;
    end
    i2c_stop();
    check_txn(tag);
  endtask

  // Read transaction, optionally setting the pointer first via repeated START.
  task automatic read_txn(input string tag, input logic set_ptr,
                          input logic [7:0] reg_addr, input int n,
                          output logic [7:0] first, output logic [7:0] second);
    logic ack;
    logic [7:0] d;
    first = 8'h00;
    second = 8'h00;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'hD0, ack);
      chk_eq({tag, "_ack_addr_w"}, 32'(ack), 32'd1);
      send_byte(reg_addr, ack);
      chk_eq({tag, "_ack_reg"}, 32'(ack), 32'd1);
      model_ptr = reg_addr;
      i2c_start();
    end
    send_byte(8'hD1, ack);
    chk_eq({tag, "_ack_addr_r"}, 32'(ack), 32'd1);
    for (int k = 0; k < n; k++) begin
      recv_byte(d, k != n - 1);
      chk_eq({tag, "_rdata"}, 32'(d), 32'(model_mem[model_ptr]));
      if (k == 0) first = d;
      if (k == 1) second = d;
      model_ptr = model_ptr + 8'd1;
    end
    i2c_stop();
    check_txn(tag);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] b0, b1, c;
    logic [6:0] bad;

    rst_n = 1'b0;
    scl = 1'b1;
    sda_drv_low = 1'b0;
    fab_clear = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 8'(i) ^ 8'hA5;
    model_ptr = 8'h00;
    repeat (5) @(negedge clk);
    chk_eq("reset_sda", 32'(sda), 32'd1);
    chk_eq("reset_wr_stb", 32'(wr_stb), 32'd0);
    chk_eq("reset_wr_addr", 32'(wr_addr), 32'd0);
    chk_eq("reset_wr_data", 32'(wr_data), 32'd0);
    chk_eq("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk_eq("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    fab_clear = 1'b0;
    wait_q(2);

    // Single write
    wq = {8'h52};
    write_txn("wr1", 8'h00);

    // Burst with pointer wrap
    wq = {8'h11, 8'h22, 8'h33};
    write_txn("burst", 8'hFE);
    chk_eq("burst_ptr_wrap", 32'(rd_addr), 32'h01);

    // Address mismatch
    i2c_start();
    send_byte(8'hD2, ack);
    chk_eq("mismatch_nack", 32'(ack), 32'd0);
    send_byte(8'h05, ack);
    chk_eq("mismatch_data_nack", 32'(ack), 32'd0);
    i2c_stop();
    check_txn("mismatch");

    // Read with repeated START
    read_txn("rd2", 1'b1, 8'h10, 2, b0, b1);
    chk_eq("rd2_byte0", 32'(b0), 32'hB5);
    chk_eq("rd2_byte1", 32'(b1), 32'hB4);
    chk_eq("rd2_ptr", 32'(rd_addr), 32'h12);

    // Abort mid-byte
    i2c_start();
    send_byte(8'hD0, ack);
    send_byte(8'h20, ack);
    model_ptr = 8'h20;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    i2c_stop();
    check_txn("abort");

    // Reset while the target drives the address ACK
    c = 8'hD0;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(c[i]);
    sda_drv_low = 1'b0;
    wait_q(1);
    chk_eq("rst_ack_driven", 32'(sda), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_eq("rst_sda_released", 32'(sda), 32'd1);
    chk_eq("rst_wr_stb", 32'(wr_stb), 32'd0);
    chk_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk_eq("rst_wr_data", 32'(wr_data), 32'd0);
    chk_eq("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 8'h00;
    scl = 1'b1;
    wait_q(2);
    scl = 1'b0;
    wait_q(1);
    send_byte(8'h33, ack);
    chk_eq("rst_ignored_nack", 32'(ack), 32'd0);
    chk_eq("rst_ignored_busy", 32'(busy), 32'd0);
    i2c_stop();
    check_txn("rst_ignored");
    wq = {8'hAB};
    write_txn("rst_fresh", 8'h05);

    // Randomized transactions
    for (int t = 0; t < 16; t++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          wq.delete();
          for (int k = 0; k < int'($urandom_range(1, 4)); k++) wq.push_back(8'($urandom));
          write_txn("rnd_wr", 8'($urandom));
        end
        2: read_txn("rnd_rd", 1'($urandom_range(0, 1)), 8'($urandom),
                    int'($urandom_range(1, 4)), b0, b1);
        default: begin
          bad = 7'($urandom);
          if (bad == 7'h68) bad = 7'h69;
          i2c_start();
          send_byte({bad, 1'($urandom)}, ack);
          chk_eq("rnd_bad_nack", 32'(ack), 32'd0);
          send_byte(8'($urandom), ack);
          i2c_stop();
          check_txn("rnd_bad");
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
